// File: rtl/flag_bank_ctrl.sv
// Sticky flag / interrupt aggregator: per-channel synchroniser, level or edge
// capture, W1C status and overrun bits, enable mask, registered irq + lowest id.
module flag_bank_ctrl #(
  parameter int              NCH      = 8,
  parameter int              SYNC     = 2,
  parameter logic [NCH-1:0]  MODE_RST = '0,
  parameter logic [NCH-1:0]  EN_RST   = '1,
  parameter int              IDW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  flag_in,
  input  logic            bus_we,
  input  logic            bus_re,
  input  logic [2:0]      bus_addr,
  input  logic [NCH-1:0]  bus_wdata,
  output logic [NCH-1:0]  bus_rdata,
  output logic            bus_rvalid,
  output logic            irq,
  output logic [IDW-1:0]  irq_id
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_OVERRUN = 3'd3;
  localparam logic [2:0] ADDR_PENDING = 3'd4;
  localparam logic [2:0] ADDR_SET     = 3'd5;

  logic [NCH-1:0] s;

  generate
    if (SYNC == 0) begin : g_nosync
      assign s = flag_in;
    end else begin : g_sync
      logic [NCH-1:0] sync_q [SYNC];
      logic [NCH-1:0] sync_d [SYNC];

      always_comb begin
        sync_d[0] = flag_in;
        for (int j = 1; j < SYNC; j++) sync_d[j] = sync_q[j-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < SYNC; j++) sync_q[j] <= '0;
        end else begin
          for (int j = 0; j < SYNC; j++) sync_q[j] <= sync_d[j];
        end
      end

      assign s = sync_q[SYNC-1];
    end
  endgenerate

  logic [NCH-1:0] status_q,  status_d;
  logic [NCH-1:0] enable_q,  enable_d;
  logic [NCH-1:0] mode_q,    mode_d;
  logic [NCH-1:0] overrun_q, overrun_d;
  logic [NCH-1:0] s_prev_q,  s_prev_d;
  logic [NCH-1:0] rdata_q,   rdata_d;
  logic           rvalid_q,  rvalid_d;
  logic           irq_q,     irq_d;
  logic [IDW-1:0] irq_id_q,  irq_id_d;

  logic [NCH-1:0] ev;
  logic [NCH-1:0] w1c_status;
  logic [NCH-1:0] w1c_overrun;
  logic [NCH-1:0] set_mask;
  logic [NCH-1:0] ov_set;
  logic [NCH-1:0] pending;

  // Capture path. A level-mode channel whose source is still high re-sets its
  // status bit every cycle, which is what makes W1C ineffective while high.
  always_comb begin
    w1c_status  = (bus_we && bus_addr == ADDR_STATUS)  ? bus_wdata : '0;
    w1c_overrun = (bus_we && bus_addr == ADDR_OVERRUN) ? bus_wdata : '0;
    set_mask    = (bus_we && bus_addr == ADDR_SET)     ? bus_wdata : '0;
    ev          = (mode_q & s & ~s_prev_q) | (~mode_q & s);
    ov_set      = mode_q & ev & status_q & ~w1c_status;
    status_d    = (status_q & ~w1c_status) | ev | set_mask;
    overrun_d   = (overrun_q & ~w1c_overrun) | ov_set;
    enable_d    = (bus_we && bus_addr == ADDR_ENABLE) ? bus_wdata : enable_q;
    mode_d      = (bus_we && bus_addr == ADDR_MODE)   ? bus_wdata : mode_q;
    s_prev_d    = s;
  end

  always_comb begin
    pending  = status_q & enable_q;
    irq_d    = |pending;
    irq_id_d = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) irq_id_d = IDW'(i);
    end
  end

  // Read port: bus_re sampled at an edge yields bus_rvalid high for exactly the
  // following cycle with bus_rdata holding the register value as it was before
  // that edge; bus_rdata keeps its last value while bus_rvalid is low.
  always_comb begin
    rvalid_d = bus_re;
    rdata_d  = rdata_q;
    if (bus_re) begin
      case (bus_addr)
        ADDR_STATUS:  rdata_d = status_q;
        ADDR_ENABLE:  rdata_d = enable_q;
        ADDR_MODE:    rdata_d = mode_q;
        ADDR_OVERRUN: rdata_d = overrun_q;
        ADDR_PENDING: rdata_d = pending;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q  <= '0;
      enable_q  <= EN_RST;
      mode_q    <= MODE_RST;
      overrun_q <= '0;
      s_prev_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      status_q  <= status_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
      s_prev_q  <= s_prev_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;
  assign irq_id     = irq_id_q;

endmodule

// File: tb/tb_flag_bank_ctrl.sv
// Bench for flag_bank_ctrl: directed scenarios plus randomized traffic against
// a per-channel behavioural model of the register and capture rules.
module tb_flag_bank_ctrl;

  localparam int             NCH      = 8;
  localparam int             SYNC     = 2;
  localparam int             IDW      = 3;
  localparam logic [NCH-1:0] MODE_RST = 8'h00;
  localparam logic [NCH-1:0] EN_RST   = 8'hFF;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] flag_in = '0;
  logic           bus_we = 1'b0;
  logic           bus_re = 1'b0;
  logic [2:0]     bus_addr = '0;
  logic [NCH-1:0] bus_wdata = '0;
  logic [NCH-1:0] bus_rdata;
  logic           bus_rvalid;
  logic           irq;
  logic [IDW-1:0] irq_id;

  always #5 clk = ~clk;

  flag_bank_ctrl #(
    .NCH(NCH), .SYNC(SYNC), .MODE_RST(MODE_RST), .EN_RST(EN_RST), .IDW(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flag_in(flag_in),
    .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .irq(irq), .irq_id(irq_id)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [NCH-1:0] m_status, m_enable, m_mode, m_over, m_prev, m_rdata;
  logic           m_rvalid, m_irq;
  logic [IDW-1:0] m_id;
  logic [NCH-1:0] m_pipe[$];

  function automatic void model_reset();
    m_status = '0; m_over = '0; m_prev = '0; m_rdata = '0;
    m_enable = EN_RST; m_mode = MODE_RST;
    m_rvalid = 1'b0; m_irq = 1'b0; m_id = '0;
    m_pipe.delete();
    for (int k = 0; k < SYNC; k++) m_pipe.push_back('0);
  endfunction

  function automatic void model_step();
    logic [NCH-1:0] s_now, n_status, n_over, pend;
    bit ev, set_b, clr_b, oclr_b;
    s_now = m_pipe[0];
    n_status = m_status;
    n_over = m_over;
    for (int i = 0; i < NCH; i++) begin
      if (m_mode[i]) ev = s_now[i] && !m_prev[i];
      else           ev = s_now[i];
      set_b  = bus_we && bus_addr == 3'd5 && bus_wdata[i];
      clr_b  = bus_we && bus_addr == 3'd0 && bus_wdata[i];
      oclr_b = bus_we && bus_addr == 3'd3 && bus_wdata[i];
      if (ev || set_b)  n_status[i] = 1'b1;
      else if (clr_b)   n_status[i] = 1'b0;
      if (m_mode[i] && ev && m_status[i] && !clr_b) n_over[i] = 1'b1;
      else if (oclr_b)                               n_over[i] = 1'b0;
    end
    pend = m_status & m_enable;
    m_irq = (pend != 0);
    m_id = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pend[i]) begin
        m_id = IDW'(i);
        break;
      end
    end
    m_rvalid = bus_re;
    if (bus_re) begin
      case (bus_addr)
        3'd0: m_rdata = m_status;
        3'd1: m_rdata = m_enable;
        3'd2: m_rdata = m_mode;
        3'd3: m_rdata = m_over;
        3'd4: m_rdata = pend;
        default: m_rdata = '0;
      endcase
    end
    if (bus_we && bus_addr == 3'd1) m_enable = bus_wdata;
    if (bus_we && bus_addr == 3'd2) m_mode = bus_wdata;
    m_status = n_status;
    m_over = n_over;
    m_prev = s_now;
    m_pipe.push_back(flag_in);
    void'(m_pipe.pop_front());
  endfunction

  // Inputs change only at the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [NCH-1:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [NCH-1:0] d, output logic v);
    bus_re = 1'b1; bus_addr = a;
    tick();
    bus_re = 1'b0;
    d = bus_rdata;
    v = bus_rvalid;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    logic [NCH-1:0] d;
    logic v;
    rst_n = 1'b0;
    model_reset();
    ticks(3);
    rst_n = 1'b1;
    n_cmp++; if (irq !== 1'b0 || irq_id !== '0) begin n_err++;
      $display("FAIL reset_irq got irq=%0b id=%0d exp 0/0", irq, irq_id); end
    n_cmp++; if (bus_rvalid !== 1'b0 || bus_rdata !== '0) begin n_err++;
      $display("FAIL reset_bus got rvalid=%0b rdata=%h exp 0/00", bus_rvalid, bus_rdata); end
    do_read(3'd1, d, v);
    n_cmp++; if (v !== 1'b1 || d !== EN_RST) begin n_err++;
      $display("FAIL reset_enable got v=%0b d=%h exp 1/%h", v, d, EN_RST); end
    do_read(3'd2, d, v);
    n_cmp++; if (d !== MODE_RST) begin n_err++;
      $display("FAIL reset_mode got %h exp %h", d, MODE_RST); end
    tick();
    n_cmp++; if (bus_rvalid !== 1'b0 || bus_rdata !== MODE_RST) begin n_err++;
      $display("FAIL rvalid_pulse got rvalid=%0b rdata=%h exp 0/%h", bus_rvalid, bus_rdata, MODE_RST); end
  endtask

  task automatic test_latency();
    do_write(3'd2, 8'hFF);
    ticks(2);
    flag_in = 8'h08;
    tick();
    flag_in = 8'h00;
    tick();
    bus_re = 1'b1; bus_addr = 3'd0;
    tick();
    n_cmp++; if (bus_rvalid !== 1'b1 || bus_rdata !== 8'h00 || irq !== 1'b0) begin n_err++;
      $display("FAIL lat_early got rv=%0b rd=%h irq=%0b exp 1/00/0", bus_rvalid, bus_rdata, irq); end
    tick();
    bus_re = 1'b0;
    n_cmp++; if (bus_rdata !== 8'h08) begin n_err++;
      $display("FAIL lat_status got %h exp 08", bus_rdata); end
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd3) begin n_err++;
      $display("FAIL lat_irq got irq=%0b id=%0d exp 1/3", irq, irq_id); end
  endtask

  task automatic test_set_beats_clear();
    logic [NCH-1:0] d;
    logic v;
    flag_in = 8'h08;
    tick();
    flag_in = 8'h00;
    tick();
    do_write(3'd0, 8'h08);
    do_read(3'd0, d, v);
    n_cmp++; if (d !== 8'h08) begin n_err++;
      $display("FAIL t2_status got %h exp 08", d); end
    do_read(3'd3, d, v);
    n_cmp++; if (d !== 8'h00) begin n_err++;
      $display("FAIL t2_overrun got %h exp 00", d); end
  endtask

  task automatic test_overrun();
    logic [NCH-1:0] d;
    logic v;
    for (int r = 0; r < 2; r++) begin
      flag_in = 8'h20;
      tick();
      flag_in = 8'h00;
      ticks(3);
    end
    do_read(3'd3, d, v);
    n_cmp++; if (d !== 8'h20) begin n_err++;
      $display("FAIL t3_overrun got %h exp 20", d); end
    do_write(3'd3, 8'h20);
    do_read(3'd3, d, v);
    n_cmp++; if (d !== 8'h00) begin n_err++;
      $display("FAIL t3_ovclr got %h exp 00", d); end
    do_read(3'd0, d, v);
    n_cmp++; if (d !== 8'h28) begin n_err++;
      $display("FAIL t3_status got %h exp 28", d); end
  endtask

  task automatic test_enable_mask();
    logic [NCH-1:0] d;
    logic v;
    do_write(3'd0, 8'hFF);
    do_write(3'd3, 8'hFF);
    do_write(3'd1, 8'hF0);
    flag_in = 8'h42;
    tick();
    flag_in = 8'h00;
    ticks(4);
    do_read(3'd0, d, v);
    n_cmp++; if (d !== 8'h42) begin n_err++;
      $display("FAIL t4_status got %h exp 42", d); end
    do_read(3'd4, d, v);
    n_cmp++; if (d !== 8'h40) begin n_err++;
      $display("FAIL t4_pending got %h exp 40", d); end
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd6) begin n_err++;
      $display("FAIL t4_id6 got irq=%0b id=%0d exp 1/6", irq, irq_id); end
    do_write(3'd1, 8'hFF);
    n_cmp++; if (irq_id !== 3'd6) begin n_err++;
      $display("FAIL t4_id_hold got %0d exp 6", irq_id); end
    tick();
    n_cmp++; if (irq_id !== 3'd1) begin n_err++;
      $display("FAIL t4_id1 got %0d exp 1", irq_id); end
  endtask

  task automatic test_level();
    logic [NCH-1:0] d;
    logic v;
    do_write(3'd2, 8'h00);
    do_write(3'd0, 8'hFF);
    flag_in = 8'h01;
    ticks(3);
    do_write(3'd0, 8'h01);
    do_read(3'd0, d, v);
    n_cmp++; if (d !== 8'h01) begin n_err++;
      $display("FAIL t5_hold got %h exp 01", d); end
    flag_in = 8'h00;
    ticks(3);
    do_write(3'd0, 8'h01);
    do_read(3'd0, d, v);
    n_cmp++; if (d !== 8'h00) begin n_err++;
      $display("FAIL t5_clear got %h exp 00", d); end
    n_cmp++; if (irq !== 1'b0 || irq_id !== '0) begin n_err++;
      $display("FAIL t5_irq got irq=%0b id=%0d exp 0/0", irq, irq_id); end
  endtask

  task automatic test_set_and_reset();
    logic [NCH-1:0] d;
    logic v;
    do_write(3'd1, 8'h0F);
    do_write(3'd2, 8'h3C);
    do_write(3'd5, 8'h81);
    do_read(3'd0, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 8'h81) begin n_err++;
      $display("FAIL t6_set got v=%0b d=%h exp 1/81", v, d); end
    do_read(3'd5, d, v);
    n_cmp++; if (d !== 8'h00) begin n_err++;
      $display("FAIL t6_set_reads0 got %h exp 00", d); end
    bus_re = 1'b1; bus_addr = 3'd0;
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    bus_re = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (irq !== 1'b0 || irq_id !== '0 || bus_rvalid !== 1'b0 || bus_rdata !== '0) begin
      n_err++;
      $display("FAIL t6_async got irq=%0b id=%0d rv=%0b rd=%h exp all 0",
               irq, irq_id, bus_rvalid, bus_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_read(3'd1, d, v);
    n_cmp++; if (d !== EN_RST) begin n_err++;
      $display("FAIL t6_enable got %h exp %h", d, EN_RST); end
    do_read(3'd2, d, v);
    n_cmp++; if (d !== MODE_RST) begin n_err++;
      $display("FAIL t6_mode got %h exp %h", d, MODE_RST); end
    do_read(3'd0, d, v);
    n_cmp++; if (d !== 8'h00) begin n_err++;
      $display("FAIL t6_status got %h exp 00", d); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      flag_in   = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : flag_in;
      bus_we    = ($urandom_range(0, 3) == 0);
      bus_re    = $urandom_range(0, 1) == 1;
      bus_addr  = 3'($urandom_range(0, 7));
      bus_wdata = NCH'($urandom);
      tick();
      n_cmp++; if (irq !== m_irq || irq_id !== m_id) begin n_err++;
        $display("FAIL rnd_irq cyc=%0d got irq=%0b id=%0d exp %0b/%0d", c, irq, irq_id, m_irq, m_id); end
      n_cmp++; if (bus_rvalid !== m_rvalid || bus_rdata !== m_rdata) begin n_err++;
        $display("FAIL rnd_bus cyc=%0d got rv=%0b rd=%h exp %0b/%h", c, bus_rvalid, bus_rdata, m_rvalid, m_rdata); end
    end
    bus_we = 1'b0; bus_re = 1'b0; flag_in = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_set_beats_clear();
    test_overrun();
    test_enable_mask();
    test_level();
    test_set_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
